// File: rtl/wb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ram_arbiter
//
// Two-port Wishbone B3 slave front-end that shares one single-port-read /
// single-port-write RAM (1-cycle registered read) between two masters.
// Round-robin arbitration, per-byte write enables, classic cycles and
// linear incrementing bursts with zero-bubble read pipelining.
//
// Ports
//   wb_clk_i, wb_rst_i          clock (rising edge), async active-high reset
//   wbs0_* / wbs1_*             Wishbone slave ports 0 and 1
//       adr_i[31:0]  byte address, word index = adr[AW+1:2]
//       dat_i[31:0]  write data       sel_i[3:0]  byte selects
//       we_i         write enable     cyc_i/stb_i cycle / strobe
//       cti_i[2:0]   cycle type       bte_i[1:0]  burst type (00 only)
//       dat_o[31:0]  read data        ack_o       acknowledge
//   ram_we[3:0]                 byte write enables to the RAM
//   ram_din[31:0]               RAM write data
//   ram_waddr[AW-1:0]           RAM write word address
//   ram_raddr[AW-1:0]           RAM read word address
//   ram_dout[31:0]              RAM read data, valid one cycle after raddr
// ---------------------------------------------------------------------------
module wb_ram_arbiter #(
    parameter int depth = 256
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,

    input  logic [31:0]                wbs0_adr_i,
    input  logic [31:0]                wbs0_dat_i,
    input  logic [3:0]                 wbs0_sel_i,
    input  logic                       wbs0_we_i,
    input  logic                       wbs0_cyc_i,
    input  logic                       wbs0_stb_i,
    input  logic [2:0]                 wbs0_cti_i,
    input  logic [1:0]                 wbs0_bte_i,
    output logic [31:0]                wbs0_dat_o,
    output logic                       wbs0_ack_o,

    input  logic [31:0]                wbs1_adr_i,
    input  logic [31:0]                wbs1_dat_i,
    input  logic [3:0]                 wbs1_sel_i,
    input  logic                       wbs1_we_i,
    input  logic                       wbs1_cyc_i,
    input  logic                       wbs1_stb_i,
    input  logic [2:0]                 wbs1_cti_i,
    input  logic [1:0]                 wbs1_bte_i,
    output logic [31:0]                wbs1_dat_o,
    output logic                       wbs1_ack_o,

    output logic [3:0]                 ram_we,
    output logic [31:0]                ram_din,
    output logic [$clog2(depth)-1:0]   ram_waddr,
    output logic [$clog2(depth)-1:0]   ram_raddr,
    input  logic [31:0]                ram_dout
);

    localparam int AW = $clog2(depth);

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [1:0] BTE_LIN  = 2'b00;

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t state, state_nxt;
    logic   gnt, gnt_nxt;     // granted port
    logic   rr, rr_nxt;       // port preferred on the next contention
    logic   ack, ack_nxt;     // registered acknowledge of the granted port

    // Word addresses; the byte-lane bits and everything above the RAM
    // depth are ignored, so addresses alias modulo the RAM size.
    logic [AW-1:0] word0, word1;
    assign word0 = wbs0_adr_i[AW+1:2];
    assign word1 = wbs1_adr_i[AW+1:2];

    logic unused_adr_bits;
    assign unused_adr_bits = ^{wbs0_adr_i[31:AW+2], wbs0_adr_i[1:0],
                               wbs1_adr_i[31:AW+2], wbs1_adr_i[1:0]};

    logic req0, req1, pick;
    assign req0 = wbs0_cyc_i & wbs0_stb_i;
    assign req1 = wbs1_cyc_i & wbs1_stb_i;

    // Port that IDLE would grant right now: the rr-preferred one on
    // contention, otherwise whichever is requesting.
    assign pick = (req0 && req1) ? rr : req1;

    // Granted-port view of the bus.
    logic [AW-1:0] g_word;
    logic [31:0]   g_dat;
    logic [3:0]    g_sel;
    logic          g_we, g_cyc, g_stb;
    logic [2:0]    g_cti;
    logic [1:0]    g_bte;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // (or on every branch); a path that leaves one unassigned infers a latch.
    always_comb begin
        if (gnt) begin
            g_word = word1;
            g_dat  = wbs1_dat_i;
            g_sel  = wbs1_sel_i;
            g_we   = wbs1_we_i;
            g_cyc  = wbs1_cyc_i;
            g_stb  = wbs1_stb_i;
            g_cti  = wbs1_cti_i;
            g_bte  = wbs1_bte_i;
        end else begin
            g_word = word0;
            g_dat  = wbs0_dat_i;
            g_sel  = wbs0_sel_i;
            g_we   = wbs0_we_i;
            g_cyc  = wbs0_cyc_i;
            g_stb  = wbs0_stb_i;
            g_cti  = wbs0_cti_i;
            g_bte  = wbs0_bte_i;
        end
    end

    // Only linear incrementing bursts keep ack high; other burst types
    // fall back to one ack per strobe.
    logic burst;
    assign burst = (g_cti == CTI_INCR) && (g_bte == BTE_LIN);

    // Next-state / next-ack logic.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        rr_nxt    = rr;
        ack_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_nxt   = pick;
                    state_nxt = ACC;
                    if (req0 && req1)
                        rr_nxt = ~rr;
                end
            end
            ACC: begin
                if (!g_cyc)
                    state_nxt = IDLE;
                else if (!ack)
                    ack_nxt = g_stb;
                else
                    // Classic: one-cycle pulse. Burst: hold while strobed;
                    // cti=111 clears 'burst' so the last beat ends the ack.
                    ack_nxt = g_stb && burst;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            gnt   <= 1'b0;
            rr    <= 1'b0;
            ack   <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            rr    <= rr_nxt;
            ack   <= ack_nxt;
        end
    end

    // Read address: during an acked burst beat, look one word ahead so the
    // registered RAM output already holds the next beat's data.
    always_comb begin
        if (state == IDLE)
            ram_raddr = pick ? word1 : word0;
        else
            ram_raddr = g_word + {{(AW-1){1'b0}}, (ack && burst)};
    end

    // Writes commit on the edge that completes the handshake; since ack is a
    // flop cleared asynchronously, reset removes the enables immediately.
    assign ram_we    = g_sel & {4{g_cyc & g_stb & g_we & ack}};
    assign ram_din   = g_dat;
    assign ram_waddr = g_word;

    assign wbs0_ack_o = ack & ~gnt;
    assign wbs1_ack_o = ack &  gnt;

    // Read data is only meaningful alongside ack, so both ports can
    // observe the RAM output directly.
    assign wbs0_dat_o = ram_dout;
    assign wbs1_dat_o = ram_dout;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_ram_arbiter
//
// Self-checking bench for wb_ram_arbiter. Models the attached RAM (byte
// writes, one-cycle registered read), drives both Wishbone ports with
// classic and burst master tasks and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_wb_ram_arbiter;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];
    logic        we  [2];
    logic        cyc [2];
    logic        stb [2];
    logic [2:0]  cti [2];
    logic [1:0]  bte [2];

    logic [31:0] dat0, dat1;
    logic        ack0, ack1;

    logic [3:0]    ram_we;
    logic [31:0]   ram_din;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [31:0]   ram_dout;

    wb_ram_arbiter #(.depth(DEPTH)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs0_adr_i (adr[0]),
        .wbs0_dat_i (dat[0]),
        .wbs0_sel_i (sel[0]),
        .wbs0_we_i  (we[0]),
        .wbs0_cyc_i (cyc[0]),
        .wbs0_stb_i (stb[0]),
        .wbs0_cti_i (cti[0]),
        .wbs0_bte_i (bte[0]),
        .wbs0_dat_o (dat0),
        .wbs0_ack_o (ack0),
        .wbs1_adr_i (adr[1]),
        .wbs1_dat_i (dat[1]),
        .wbs1_sel_i (sel[1]),
        .wbs1_we_i  (we[1]),
        .wbs1_cyc_i (cyc[1]),
        .wbs1_stb_i (stb[1]),
        .wbs1_cti_i (cti[1]),
        .wbs1_bte_i (bte[1]),
        .wbs1_dat_o (dat1),
        .wbs1_ack_o (ack1),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .ram_waddr  (ram_waddr),
        .ram_raddr  (ram_raddr),
        .ram_dout   (ram_dout)
    );

    // RAM model: byte-lane writes, read-before-write registered read.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};
    int          wcount = 0;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b])
                mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= mem[ram_raddr];
        if (ram_we != 4'b0000)
            wcount <= wcount + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? ack0 : ack1;
    endfunction

    function automatic logic [31:0] dat_of(input int p);
        return (p == 0) ? dat0 : dat1;
    endfunction

    task automatic idle_port(input int p);
        cyc[p] = 1'b0; stb[p] = 1'b0; we[p] = 1'b0;
        adr[p] = 32'h0; dat[p] = 32'h0; sel[p] = 4'h0;
        cti[p] = 3'b000; bte[p] = 2'b00;
    endtask

    // One classic access; reports ack count, latency (negedge index of the
    // first ack, counted from the request edge) and the read data.
    task automatic classic(input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd, output int nack, output int lat);
        logic got;
        @(posedge clk); #1;
        cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w; adr[p] = a; dat[p] = d;
        sel[p] = s; cti[p] = 3'b000; bte[p] = 2'b00;
        nack = 0; lat = -1; rd = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            got = ack_of(p);
            if (got) begin
                nack++;
                if (lat < 0) begin
                    lat = i;
                    rd  = dat_of(p);
                end
            end
            @(posedge clk); #1;
            if (got) idle_port(p);
        end
    endtask

    // Incrementing burst of n beats; read data lands in rd_buf.
    logic [31:0] rd_buf [8];

    task automatic burst(input int p, input logic w, input logic [31:0] a, input int n,
                         input logic [1:0] b, input logic [31:0] wbase,
                         output int nack, output int span);
        logic got;
        int   k, first, last;
        @(posedge clk); #1;
        cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w; adr[p] = a; dat[p] = wbase;
        sel[p] = 4'hF; bte[p] = b; cti[p] = (n == 1) ? 3'b111 : 3'b010;
        k = 0; first = -1; last = -1; nack = 0;
        for (int i = 0; i < 2*n + 8; i++) begin
            @(negedge clk);
            got = ack_of(p);
            if (got) begin
                if (first < 0) first = i;
                last = i;
                if (k < 8) rd_buf[k] = dat_of(p);
                nack++;
            end
            @(posedge clk); #1;
            if (got && k < n) begin
                k++;
                if (k == n) begin
                    idle_port(p);
                end else begin
                    adr[p] = adr[p] + 32'd4;
                    dat[p] = wbase + k;
                    cti[p] = (k == n - 1) ? 3'b111 : 3'b010;
                end
            end
        end
        span = last - first;
    endtask

    // Both ports raise a classic read together; reports which port is
    // acked first and the data each one saw.
    task automatic pair_round(input logic [31:0] a0, input logic [31:0] a1,
                              output int first, output logic [31:0] d0,
                              output logic [31:0] d1, output int ndone);
        logic g0, g1;
        logic done0, done1;
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = 1'b0; sel[p] = 4'hF;
            cti[p] = 3'b000; bte[p] = 2'b00;
        end
        adr[0] = a0; adr[1] = a1;
        first = -1; done0 = 1'b0; done1 = 1'b0; d0 = 32'h0; d1 = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            g0 = ack0 && !done0;
            g1 = ack1 && !done1;
            if (g0 && g1) first = 2;
            else if (first < 0 && g0) first = 0;
            else if (first < 0 && g1) first = 1;
            if (g0) d0 = dat0;
            if (g1) d1 = dat1;
            @(posedge clk); #1;
            if (g0) begin idle_port(0); done0 = 1'b1; end
            if (g1) begin idle_port(1); done1 = 1'b1; end
        end
        ndone = int'(done0) + int'(done1);
    endtask

    typedef struct {
        int          port;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [31:0] rd, d0, d1;
        int          nack, lat, span, first, ndone, k, wc;
        logic        got;

        vecs[0]  = '{0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEEF};
        vecs[2]  = '{1, 1'b1, 32'h020, 32'h11223344, 4'hF, 32'h0};
        vecs[3]  = '{1, 1'b1, 32'h020, 32'h0000AB00, 4'h2, 32'h0};
        vecs[4]  = '{1, 1'b0, 32'h020, 32'h0,        4'hF, 32'h1122AB44};
        vecs[5]  = '{0, 1'b0, 32'h020, 32'h0,        4'hF, 32'h1122AB44};
        vecs[6]  = '{1, 1'b0, 32'h410, 32'h0,        4'hF, 32'hDEADBEEF};
        vecs[7]  = '{0, 1'b1, 32'h000, 32'hA0000000, 4'hF, 32'h0};
        vecs[8]  = '{1, 1'b1, 32'h004, 32'hA0000001, 4'hF, 32'h0};
        vecs[9]  = '{0, 1'b1, 32'h008, 32'hA0000002, 4'hF, 32'h0};
        vecs[10] = '{1, 1'b1, 32'h00C, 32'hA0000003, 4'hF, 32'h0};

        idle_port(0);
        idle_port(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack0", {31'b0, ack0}, 32'h0);
        check("reset_ack1", {31'b0, ack1}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_we", {28'b0, ram_we}, 32'h0);

        // Classic accesses from the vector table.
        for (int i = 0; i < 11; i++) begin
            classic(vecs[i].port, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, rd, nack, lat);
            check($sformatf("vec%0d_nack", i), nack, 1);
            check($sformatf("vec%0d_latency", i), lat, 2);
            if (!vecs[i].w)
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end

        // Simultaneous requests: the first winner alternates 0,1,0,1.
        for (int r = 0; r < 4; r++) begin
            pair_round(32'h010, 32'h020, first, d0, d1, ndone);
            check($sformatf("rr%0d_first", r), first, r % 2);
            check($sformatf("rr%0d_done", r), ndone, 2);
            check($sformatf("rr%0d_d0", r), d0, 32'hDEADBEEF);
            check($sformatf("rr%0d_d1", r), d1, 32'h1122AB44);
        end

        // Four-beat incrementing burst read, no bubbles.
        burst(0, 1'b0, 32'h000, 4, 2'b00, 32'h0, nack, span);
        check("bread_nack", nack, 4);
        check("bread_span", span, 3);
        for (int i = 0; i < 4; i++)
            check($sformatf("bread_d%0d", i), rd_buf[i], 32'hA0000000 + i);

        // Burst write across the top of the RAM, wrapping to word 0.
        burst(1, 1'b1, 32'h3F8, 4, 2'b00, 32'hC0DE0000, nack, span);
        check("bwrite_nack", nack, 4);
        check("bwrite_span", span, 3);
        check("bwrite_m254", mem[254], 32'hC0DE0000);
        check("bwrite_m255", mem[255], 32'hC0DE0001);
        check("bwrite_m0",   mem[0],   32'hC0DE0002);
        check("bwrite_m1",   mem[1],   32'hC0DE0003);

        // Read it back: the look-ahead address must wrap from 255 to 0.
        burst(0, 1'b0, 32'h3F8, 4, 2'b00, 32'h0, nack, span);
        check("bwrap_nack", nack, 4);
        check("bwrap_span", span, 3);
        for (int i = 0; i < 4; i++)
            check($sformatf("bwrap_d%0d", i), rd_buf[i], 32'hC0DE0000 + i);

        // Non-linear burst type: one ack per strobe, a gap between beats.
        burst(1, 1'b0, 32'h008, 2, 2'b01, 32'h0, nack, span);
        check("bte_nack", nack, 2);
        check("bte_span", span, 2);
        check("bte_d0", rd_buf[0], 32'hA0000002);
        check("bte_d1", rd_buf[1], 32'hA0000003);

        // Reset asserted while a burst write holds ack high on beat 2.
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h040;
        dat[0] = 32'h77770000; sel[0] = 4'hF; cti[0] = 3'b010; bte[0] = 2'b00;
        k = 0;
        for (int i = 0; i < 12 && !rst; i++) begin
            @(negedge clk);
            got = ack0;
            if (got && k == 2) begin
                rst = 1'b1;
                #1;
                check("rst_ack_kill", {31'b0, ack0}, 32'h0);
                check("rst_we_kill", {28'b0, ram_we}, 32'h0);
            end else begin
                @(posedge clk); #1;
                if (got) begin
                    k++;
                    adr[0] = adr[0] + 32'd4;
                    dat[0] = 32'h77770000 + k;
                end
            end
        end
        check("rst_reached", {31'b0, rst}, 32'h1);
        wc = wcount;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_writes", wcount, wc);
        check("rst_m16", mem[16], 32'h77770000);
        check("rst_m17", mem[17], 32'h77770001);
        check("rst_m18", mem[18], 32'h0);
        idle_port(0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack_after", {31'b0, ack0}, 32'h0);

        // Accesses after reset work normally.
        classic(0, 1'b0, 32'h044, 32'h0, 4'hF, rd, nack, lat);
        check("after_rst_nack", nack, 1);
        check("after_rst_lat", lat, 2);
        check("after_rst_rd", rd, 32'h77770001);
        classic(1, 1'b1, 32'h048, 32'h5A5A5A5A, 4'h9, rd, nack, lat);
        check("after_rst_wnack", nack, 1);
        classic(1, 1'b0, 32'h048, 32'h0, 4'hF, rd, nack, lat);
        check("after_rst_rd2", rd, 32'h5A00005A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
